// File: rtl/load_store_unit.sv
// Load/store unit between execute and a byte-wide data memory.
// Each access is split into 1/2/4 single-byte memory cycles; loads are assembled little-endian.
module load_store_unit #(
    parameter int unsigned ADDR_W = 12
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_we,
    input  logic [2:0]        req_func3,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [31:0]       req_wdata,
    output logic              resp_valid,
    output logic [31:0]       resp_rdata,
    output logic              resp_err,
    output logic              busy,
    output logic [ADDR_W-1:0] mem_addr,
    output logic              mem_we,
    output logic [7:0]        mem_wdata,
    input  logic [7:0]        mem_rdata
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_ACCESS,
        S_DONE
    } state_t;

    function automatic logic f3_legal(input logic [2:0] f);
        return (f == 3'b000) || (f == 3'b001) || (f == 3'b010) ||
               (f == 3'b100) || (f == 3'b101);
    endfunction

    // Index of the final byte cycle for a legal width code.
    function automatic logic [1:0] f3_last(input logic [2:0] f);
        case (f[1:0])
            2'b00:   return 2'd0;
            2'b01:   return 2'd1;
            default: return 2'd3;
        endcase
    endfunction

    function automatic logic [31:0] extend(input logic [2:0] f, input logic [31:0] b);
        case (f)
            3'b000:  return {{24{b[7]}}, b[7:0]};
            3'b100:  return {24'b0, b[7:0]};
            3'b001:  return {{16{b[15]}}, b[15:0]};
            3'b101:  return {16'b0, b[15:0]};
            3'b010:  return b;
            default: return 32'b0;
        endcase
    endfunction

    state_t              r_state, w_state_nxt;
    logic                r_we, w_we_nxt;
    logic [2:0]          r_func3, w_func3_nxt;
    logic [ADDR_W-1:0]   r_addr, w_addr_nxt;
    logic [31:0]         r_wdata, w_wdata_nxt;
    logic [1:0]          r_k, w_k_nxt, w_k_inc;
    logic [31:0]         r_buf, w_buf_nxt;
    logic [ADDR_W-1:0]   w_mem_addr_nxt;
    logic                w_mem_we_nxt;
    logic [7:0]          w_mem_wdata_nxt;
    logic                w_resp_valid_nxt;
    logic                w_resp_err_nxt;
    logic [31:0]         w_resp_rdata_nxt;

    assign w_k_inc = r_k + 2'd1;

    // Next state plus the next value of every registered output.
    always_comb begin
        w_state_nxt      = r_state;
        w_we_nxt         = r_we;
        w_func3_nxt      = r_func3;
        w_addr_nxt       = r_addr;
        w_wdata_nxt      = r_wdata;
        w_k_nxt          = r_k;
        w_buf_nxt        = r_buf;
        w_mem_addr_nxt   = '0;
        w_mem_we_nxt     = 1'b0;
        w_mem_wdata_nxt  = 8'h00;
        w_resp_valid_nxt = 1'b0;
        w_resp_err_nxt   = 1'b0;
        w_resp_rdata_nxt = 32'h0;

        case (r_state)
            S_IDLE: begin
                if (req_valid) begin
                    w_we_nxt    = req_we;
                    w_func3_nxt = req_func3;
                    w_addr_nxt  = req_addr;
                    w_wdata_nxt = req_wdata;
                    w_k_nxt     = 2'd0;
                    w_buf_nxt   = 32'h0;
                    if (f3_legal(req_func3)) begin
                        w_state_nxt     = S_ACCESS;
                        w_mem_addr_nxt  = req_addr;
                        w_mem_we_nxt    = req_we;
                        w_mem_wdata_nxt = req_wdata[7:0];
                    end else begin
                        w_state_nxt      = S_DONE;
                        w_resp_valid_nxt = 1'b1;
                        w_resp_err_nxt   = 1'b1;
                    end
                end
            end
            S_ACCESS: begin
                if (!r_we) begin
                    w_buf_nxt[{r_k, 3'b000} +: 8] = mem_rdata;
                end
                if (r_k == f3_last(r_func3)) begin
                    w_state_nxt      = S_DONE;
                    w_resp_valid_nxt = 1'b1;
                    w_resp_rdata_nxt = r_we ? 32'h0 : extend(r_func3, w_buf_nxt);
                end else begin
                    w_k_nxt         = w_k_inc;
                    w_mem_addr_nxt  = r_addr + ADDR_W'(w_k_inc);
                    w_mem_we_nxt    = r_we;
                    w_mem_wdata_nxt = r_wdata[{w_k_inc, 3'b000} +: 8];
                end
            end
            S_DONE: begin
                w_state_nxt = S_IDLE;
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state    <= S_IDLE;
            r_we       <= 1'b0;
            r_func3    <= 3'b000;
            r_addr     <= '0;
            r_wdata    <= 32'h0;
            r_k        <= 2'd0;
            r_buf      <= 32'h0;
            req_ready  <= 1'b1;
            busy       <= 1'b0;
            resp_valid <= 1'b0;
            resp_err   <= 1'b0;
            resp_rdata <= 32'h0;
            mem_addr   <= '0;
            mem_we     <= 1'b0;
            mem_wdata  <= 8'h00;
        end else begin
            r_state    <= w_state_nxt;
            r_we       <= w_we_nxt;
            r_func3    <= w_func3_nxt;
            r_addr     <= w_addr_nxt;
            r_wdata    <= w_wdata_nxt;
            r_k        <= w_k_nxt;
            r_buf      <= w_buf_nxt;
            req_ready  <= (w_state_nxt == S_IDLE);
            busy       <= (w_state_nxt != S_IDLE);
            resp_valid <= w_resp_valid_nxt;
            resp_err   <= w_resp_err_nxt;
            resp_rdata <= w_resp_rdata_nxt;
            mem_addr   <= w_mem_addr_nxt;
            mem_we     <= w_mem_we_nxt;
            mem_wdata  <= w_mem_wdata_nxt;
        end
    end

endmodule

// File: tb/tb_load_store_unit.sv
// Self-checking bench for load_store_unit: directed cases plus randomized traffic
// checked against a byte-array memory model.
module tb_load_store_unit;

    localparam int unsigned ADDR_W = 12;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic              req_valid = 1'b0;
    logic              req_ready;
    logic              req_we = 1'b0;
    logic [2:0]        req_func3 = 3'b000;
    logic [ADDR_W-1:0] req_addr = '0;
    logic [31:0]       req_wdata = 32'h0;
    logic              resp_valid;
    logic [31:0]       resp_rdata;
    logic              resp_err;
    logic              busy;
    logic [ADDR_W-1:0] mem_addr;
    logic              mem_we;
    logic [7:0]        mem_wdata;
    logic [7:0]        mem_rdata;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;

    logic [7:0] mem     [0:4095];
    logic [7:0] ref_mem [0:4095];

    load_store_unit #(.ADDR_W(ADDR_W)) dut (
        .clk        (clk),
        .rst        (rst),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_we     (req_we),
        .req_func3  (req_func3),
        .req_addr   (req_addr),
        .req_wdata  (req_wdata),
        .resp_valid (resp_valid),
        .resp_rdata (resp_rdata),
        .resp_err   (resp_err),
        .busy       (busy),
        .mem_addr   (mem_addr),
        .mem_we     (mem_we),
        .mem_wdata  (mem_wdata),
        .mem_rdata  (mem_rdata)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Byte-wide data memory with combinational read.
    assign mem_rdata = mem[mem_addr];
    always @(posedge clk) if (mem_we) mem[mem_addr] <= mem_wdata;

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    function automatic int n_of(input logic [2:0] f);
        case (f)
            3'b000, 3'b100: return 1;
            3'b001, 3'b101: return 2;
            3'b010:         return 4;
            default:        return 0;
        endcase
    endfunction

    function automatic logic [11:0] wrap(input logic [11:0] a, input int i);
        return 12'((int'(a) + i) % 4096);
    endfunction

    function automatic logic [31:0] ref_load(input logic [2:0] f, input logic [11:0] a);
        longint v = 0;
        for (int i = 0; i < n_of(f); i++) v += longint'(ref_mem[wrap(a, i)]) * (longint'(1) << (8 * i));
        if (f == 3'b000 && v >= 128)   v -= 256;
        if (f == 3'b001 && v >= 32768) v -= 65536;
        return 32'(v);
    endfunction

    task automatic ref_store(input logic [2:0] f, input logic [11:0] a, input logic [31:0] wd);
        for (int i = 0; i < n_of(f); i++) ref_mem[wrap(a, i)] = 8'((wd >> (8 * i)) & 32'hFF);
    endtask

    // Issue one request and wait for its response; lat counts cycles from the accept edge.
    task automatic do_access(input logic we, input logic [2:0] f3, input logic [11:0] a,
                             input logic [31:0] wd, output logic [31:0] rd, output logic er,
                             output int lat, output bit saw_we, output int acc_cyc);
        int guard = 0;
        @(negedge clk);
        req_valid = 1'b1; req_we = we; req_func3 = f3; req_addr = a; req_wdata = wd;
        while (!req_ready && guard < 50) begin @(negedge clk); guard++; end
        if (!req_ready) begin
            total++; bad++;
            $display("FAIL accept_timeout: req_ready=%0b required 1", req_ready);
        end
        @(posedge clk); #1;
        acc_cyc = cyc;
        req_valid = 1'b0;
        lat = 0; saw_we = 1'b0;
        @(negedge clk);
        while (!resp_valid && lat < 20) begin
            if (mem_we) saw_we = 1'b1;
            @(negedge clk);
            lat++;
        end
        rd = resp_rdata; er = resp_err;
        if (!resp_valid) begin
            total++; bad++;
            $display("FAIL resp_timeout: resp_valid=%0b required 1", resp_valid);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) @(negedge clk);
        total++; if (req_ready !== 1'b1)   begin bad++; $display("FAIL rst_req_ready: got %0b want 1", req_ready); end
        total++; if (busy !== 1'b0)        begin bad++; $display("FAIL rst_busy: got %0b want 0", busy); end
        total++; if (resp_valid !== 1'b0)  begin bad++; $display("FAIL rst_resp_valid: got %0b want 0", resp_valid); end
        total++; if (resp_err !== 1'b0)    begin bad++; $display("FAIL rst_resp_err: got %0b want 0", resp_err); end
        total++; if (resp_rdata !== 32'h0) begin bad++; $display("FAIL rst_resp_rdata: got %h want 0", resp_rdata); end
        total++; if (mem_we !== 1'b0)      begin bad++; $display("FAIL rst_mem_we: got %0b want 0", mem_we); end
        total++; if (mem_addr !== 12'h0)   begin bad++; $display("FAIL rst_mem_addr: got %h want 0", mem_addr); end
        total++; if (mem_wdata !== 8'h0)   begin bad++; $display("FAIL rst_mem_wdata: got %h want 0", mem_wdata); end
        rst = 1'b0;
    endtask

    task automatic test_word();
        logic [31:0] rd; logic er; int lat; bit sw; int ac;
        logic [7:0] exp_b [4];
        exp_b = '{8'hEF, 8'hBE, 8'hAD, 8'hDE};
        do_access(1'b1, 3'b010, 12'h010, 32'hDEADBEEF, rd, er, lat, sw, ac);
        ref_store(3'b010, 12'h010, 32'hDEADBEEF);
        total++; if (rd !== 32'h0) begin bad++; $display("FAIL sw_rdata: got %h want 0", rd); end
        total++; if (lat != 4)     begin bad++; $display("FAIL sw_latency: got %0d want 4", lat); end
        for (int i = 0; i < 4; i++) begin
            total++;
            if (mem[12'h010 + 12'(i)] !== exp_b[i]) begin
                bad++; $display("FAIL sw_mem_byte%0d: got %h want %h", i, mem[12'h010 + 12'(i)], exp_b[i]);
            end
        end
        do_access(1'b0, 3'b010, 12'h010, 32'h0, rd, er, lat, sw, ac);
        total++; if (rd !== 32'hDEADBEEF) begin bad++; $display("FAIL lw_rdata: got %h want deadbeef", rd); end
        total++; if (lat != 4)            begin bad++; $display("FAIL lw_latency: got %0d want 4", lat); end
        total++; if (sw)                  begin bad++; $display("FAIL lw_mem_we: got 1 want 0"); end
    endtask

    task automatic test_byte_half();
        logic [31:0] rd; logic er; int lat; bit sw; int ac;
        do_access(1'b1, 3'b000, 12'h020, 32'h00000080, rd, er, lat, sw, ac);
        do_access(1'b1, 3'b000, 12'h013, 32'h00000034, rd, er, lat, sw, ac);
        do_access(1'b1, 3'b000, 12'h014, 32'h00000092, rd, er, lat, sw, ac);
        total++; if (lat != 1) begin bad++; $display("FAIL sb_latency: got %0d want 1", lat); end
        do_access(1'b0, 3'b000, 12'h020, 32'h0, rd, er, lat, sw, ac);
        total++; if (rd !== 32'hFFFFFF80) begin bad++; $display("FAIL lb_rdata: got %h want ffffff80", rd); end
        total++; if (lat != 1)            begin bad++; $display("FAIL lb_latency: got %0d want 1", lat); end
        do_access(1'b0, 3'b100, 12'h020, 32'h0, rd, er, lat, sw, ac);
        total++; if (rd !== 32'h00000080) begin bad++; $display("FAIL lbu_rdata: got %h want 00000080", rd); end
        do_access(1'b0, 3'b001, 12'h013, 32'h0, rd, er, lat, sw, ac);
        total++; if (rd !== 32'hFFFF9234) begin bad++; $display("FAIL lh_rdata: got %h want ffff9234", rd); end
        total++; if (lat != 2)            begin bad++; $display("FAIL lh_latency: got %0d want 2", lat); end
        do_access(1'b0, 3'b101, 12'h013, 32'h0, rd, er, lat, sw, ac);
        total++; if (rd !== 32'h00009234) begin bad++; $display("FAIL lhu_rdata: got %h want 00009234", rd); end
    endtask

    task automatic test_wrap();
        logic [31:0] rd; logic er; int lat; bit sw; int ac;
        logic [11:0] wa [4];
        logic [7:0]  wb [4];
        wa = '{12'hFFE, 12'hFFF, 12'h000, 12'h001};
        wb = '{8'h44, 8'h33, 8'h22, 8'h11};
        do_access(1'b1, 3'b010, 12'hFFE, 32'h11223344, rd, er, lat, sw, ac);
        for (int i = 0; i < 4; i++) begin
            total++;
            if (mem[wa[i]] !== wb[i]) begin
                bad++; $display("FAIL wrap_mem_%h: got %h want %h", wa[i], mem[wa[i]], wb[i]);
            end
        end
        do_access(1'b0, 3'b010, 12'hFFE, 32'h0, rd, er, lat, sw, ac);
        total++; if (rd !== 32'h11223344) begin bad++; $display("FAIL wrap_lw: got %h want 11223344", rd); end
    endtask

    task automatic test_illegal();
        logic [31:0] rd; logic er; int lat; bit sw; int ac;
        logic [2:0] codes [3];
        codes = '{3'b011, 3'b110, 3'b111};
        for (int i = 0; i < 3; i++) begin
            do_access(1'b1, codes[i], 12'h200, 32'hFFFFFFFF, rd, er, lat, sw, ac);
            total++; if (er !== 1'b1)  begin bad++; $display("FAIL ill_err_%0d: got %0b want 1", i, er); end
            total++; if (rd !== 32'h0) begin bad++; $display("FAIL ill_rdata_%0d: got %h want 0", i, rd); end
            total++; if (lat != 0)     begin bad++; $display("FAIL ill_latency_%0d: got %0d want 0", i, lat); end
            total++; if (sw || mem_we) begin bad++; $display("FAIL ill_mem_we_%0d: got 1 want 0", i); end
            @(negedge clk);
            total++; if (req_ready !== 1'b1) begin bad++; $display("FAIL ill_ready_%0d: got %0b want 1", i, req_ready); end
        end
    endtask

    task automatic test_reset_mid();
        logic [31:0] rd; logic er; int lat; bit sw; int ac;
        bit saw_resp = 1'b0;
        do_access(1'b1, 3'b010, 12'h040, 32'h00000000, rd, er, lat, sw, ac);
        @(negedge clk);
        req_valid = 1'b1; req_we = 1'b1; req_func3 = 3'b010; req_addr = 12'h040; req_wdata = 32'hAABBCCDD;
        total++; if (req_ready !== 1'b1) begin bad++; $display("FAIL rmid_ready: got %0b want 1", req_ready); end
        @(posedge clk); #1;
        req_valid = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        if (resp_valid) saw_resp = 1'b1;
        rst = 1'b1;
        #1;
        total++; if (mem_we !== 1'b0)    begin bad++; $display("FAIL rmid_mem_we: got %0b want 0", mem_we); end
        total++; if (req_ready !== 1'b1) begin bad++; $display("FAIL rmid_req_ready: got %0b want 1", req_ready); end
        repeat (2) @(negedge clk);
        rst = 1'b0;
        repeat (4) begin @(negedge clk); if (resp_valid) saw_resp = 1'b1; end
        total++; if (saw_resp) begin bad++; $display("FAIL rmid_resp: got resp_valid=1 want 0"); end
        total++;
        if (mem[12'h040] !== 8'hDD || mem[12'h041] !== 8'hCC || mem[12'h042] !== 8'h00 || mem[12'h043] !== 8'h00) begin
            bad++; $display("FAIL rmid_mem: got %h %h %h %h want dd cc 00 00",
                            mem[12'h040], mem[12'h041], mem[12'h042], mem[12'h043]);
        end
        do_access(1'b0, 3'b000, 12'h041, 32'h0, rd, er, lat, sw, ac);
        total++; if (rd !== 32'hFFFFFFCC) begin bad++; $display("FAIL rmid_lb: got %h want ffffffcc", rd); end
    endtask

    task automatic test_random();
        logic [31:0] rd; logic er; int lat; bit sw; int ac;
        logic [2:0] legal [5];
        int mism = 0;
        legal = '{3'b000, 3'b001, 3'b010, 3'b100, 3'b101};
        for (int i = 0; i < 16; i++) begin
            logic [31:0] d = $urandom;
            do_access(1'b1, 3'b010, 12'h100 + 12'(4 * i), d, rd, er, lat, sw, ac);
            ref_store(3'b010, 12'h100 + 12'(4 * i), d);
        end
        for (int i = 0; i < 200; i++) begin
            logic we = 1'($urandom_range(0, 1));
            logic [2:0] f = ($urandom_range(0, 9) == 0) ? 3'b011 + 3'($urandom_range(0, 2)) * 3'b011 % 3'b111
                                                        : legal[$urandom_range(0, 4)];
            logic [11:0] a = 12'h100 + 12'($urandom_range(0, 60));
            logic [31:0] d = $urandom;
            bit ok = (n_of(f) != 0);
            logic [31:0] exp_rd = (we || !ok) ? 32'h0 : ref_load(f, a);
            do_access(we, f, a, d, rd, er, lat, sw, ac);
            if (we && ok) ref_store(f, a, d);
            total++; if (rd !== exp_rd)     begin bad++; $display("FAIL rnd_rdata_%0d: f3=%b a=%h got %h want %h", i, f, a, rd, exp_rd); end
            total++; if (er !== !ok)        begin bad++; $display("FAIL rnd_err_%0d: got %0b want %0b", i, er, !ok); end
            total++; if (lat != n_of(f))    begin bad++; $display("FAIL rnd_latency_%0d: got %0d want %0d", i, lat, n_of(f)); end
        end
        for (int j = 12'h100; j < 12'h140; j++) if (mem[12'(j)] !== ref_mem[12'(j)]) mism++;
        total++; if (mism != 0) begin bad++; $display("FAIL rnd_mem_image: got %0d differing bytes want 0", mism); end
    endtask

    task automatic test_back_to_back();
        logic [31:0] rd; logic er; int lat; bit sw; int ac;
        int prev_ac = -1;
        int prev_n  = 0;
        logic [2:0] seq [6];
        seq = '{3'b010, 3'b000, 3'b011, 3'b001, 3'b101, 3'b010};
        for (int i = 0; i < 6; i++) begin
            logic [11:0] a = 12'h104 + 12'(2 * i);
            logic [31:0] exp_rd = (n_of(seq[i]) == 0) ? 32'h0 : ref_load(seq[i], a);
            do_access(1'b0, seq[i], a, 32'h0, rd, er, lat, sw, ac);
            if (prev_ac >= 0) begin
                total++;
                if (ac - prev_ac != prev_n + 2) begin
                    bad++; $display("FAIL b2b_gap_%0d: got %0d want %0d", i, ac - prev_ac, prev_n + 2);
                end
            end
            total++; if (rd !== exp_rd) begin bad++; $display("FAIL b2b_rdata_%0d: got %h want %h", i, rd, exp_rd); end
            prev_ac = ac;
            prev_n  = n_of(seq[i]);
        end
    endtask

    initial begin
        test_reset();
        test_word();
        test_byte_half();
        test_wrap();
        test_illegal();
        test_reset_mid();
        test_random();
        test_back_to_back();
        repeat (2) @(negedge clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
